// File: rtl/field_pkg.sv
// Shared types and helpers for the vector-field frame sequencer.
package field_pkg;

    localparam int unsigned DEFAULT_COMP_W = 32;

    // One RAM entry at the default component width, xn in the MSBs.
    typedef struct packed {
        logic [DEFAULT_COMP_W-1:0] xn;
        logic [DEFAULT_COMP_W-1:0] yn;
        logic [DEFAULT_COMP_W-1:0] mag;
    } field_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        START,
        WAIT_DONE,
        WAIT_FRAME
    } seq_state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/field_addr_gen.sv
// Column/row/address walker for one field fill, plus the per-column magnitude
// ramp built from an accumulator (no multiplier).
module field_addr_gen
    import field_pkg::*;
#(
    parameter int unsigned FIELD_WIDTH  = 8,
    parameter int unsigned FIELD_HEIGHT = 6,
    parameter int unsigned COMP_W       = DEFAULT_COMP_W,
    parameter int unsigned MAG_STEP     = 0,
    parameter int unsigned ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [COMP_W-1:0] mag_seed,
    output logic [ADDR_W-1:0] addr,
    output logic [COMP_W-1:0] mag,
    output logic              last
);

    localparam int unsigned       COL_W    = clog2_min1(FIELD_WIDTH);
    localparam int unsigned       ROW_W    = clog2_min1(FIELD_HEIGHT);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(FIELD_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(FIELD_HEIGHT - 1);
    localparam logic [COMP_W-1:0] STEP     = COMP_W'(MAG_STEP);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COMP_W-1:0] acc_q, acc_d;
    logic [COMP_W-1:0] base_q, base_d;

    // Next-state for the walker: clear loads the base magnitude, advance steps one cell.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        acc_d  = acc_q;
        base_d = base_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
            acc_d  = mag_seed;
            base_d = mag_seed;
        end else if (advance) begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                acc_d = base_q;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
                acc_d = acc_q + STEP;
            end
        end
    end

    // Walker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            acc_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            acc_q  <= acc_d;
            base_q <= base_d;
        end
    end

    assign addr = addr_q;
    assign mag  = acc_q;
    assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/field_sequencer.sv
// Frame-level controller: fills the vector-field RAM, kicks the line renderer,
// waits for its done and paces the next frame on frame_tick.
// Optional watchdog on the renderer wait: define FIELD_SEQ_TIMEOUT_EN.
module field_sequencer
    import field_pkg::*;
#(
    parameter int unsigned FIELD_WIDTH  = 8,
    parameter int unsigned FIELD_HEIGHT = 6,
    parameter int unsigned COMP_W       = DEFAULT_COMP_W,
    parameter int unsigned MAG_STEP     = 0,
    parameter int unsigned FRAME_CNT_W  = 16,
    parameter int unsigned TIMEOUT_CYC  = 1000000,
    localparam int unsigned FIELD_SIZE  = FIELD_WIDTH * FIELD_HEIGHT,
    localparam int unsigned FIELD_ADDRW = $clog2(FIELD_SIZE),
    localparam int unsigned FIELD_DATAW = 3 * COMP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   step,
    input  logic                   frame_tick,
    input  logic [COMP_W-1:0]      seed_xn,
    input  logic [COMP_W-1:0]      seed_yn,
    input  logic [COMP_W-1:0]      seed_mag,
    output logic                   field_we,
    output logic [FIELD_ADDRW-1:0] field_addr,
    output logic [FIELD_DATAW-1:0] field_data,
    output logic                   draw_start,
    input  logic                   draw_done,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout
);

    seq_state_t state_q, state_d;

    logic                   pend_q, pend_d;
    logic [FRAME_CNT_W-1:0] fc_q, fc_d;
    logic                   busy_q;
    logic [COMP_W-1:0]      xn_q, yn_q;
    logic                   fill_enter;
    logic                   wd_expired;

    logic [FIELD_ADDRW-1:0] gen_addr;
    logic [COMP_W-1:0]      gen_mag;
    logic                   gen_last;

    field_addr_gen #(
        .FIELD_WIDTH  (FIELD_WIDTH),
        .FIELD_HEIGHT (FIELD_HEIGHT),
        .COMP_W       (COMP_W),
        .MAG_STEP     (MAG_STEP),
        .ADDR_W       (FIELD_ADDRW)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (fill_enter),
        .advance  (state_q == FILL),
        .mag_seed (seed_mag),
        .addr     (gen_addr),
        .mag      (gen_mag),
        .last     (gen_last)
    );

`ifdef FIELD_SEQ_TIMEOUT_EN
    localparam int unsigned     WD_W    = clog2_min1(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    assign wd_expired = (wd_q == WD_LAST);

    // Watchdog counts cycles spent in WAIT_DONE; the flag is sticky until reset.
    always_comb begin
        wd_d      = (state_q == WAIT_DONE) ? wd_q + WD_W'(1) : '0;
        timeout_d = timeout_q;
        if ((state_q == WAIT_DONE) && !draw_done && wd_expired) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign wd_expired         = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Next-state, pending-tick and frame-count logic.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        fc_d    = fc_q;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (run || step) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (frame_tick) begin
                    pend_d = 1'b1;
                end
                if (gen_last) begin
                    state_d = START;
                end
            end
            START: begin
                if (frame_tick) begin
                    pend_d = 1'b1;
                end
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (frame_tick) begin
                    pend_d = 1'b1;
                end
                if (draw_done) begin
                    fc_d    = fc_q + FRAME_CNT_W'(1);
                    state_d = run ? WAIT_FRAME : IDLE;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            WAIT_FRAME: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (frame_tick || pend_q) begin
                    state_d = FILL;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Seeds and counters restart on every entry into FILL.
    assign fill_enter = (state_d == FILL) && (state_q != FILL);

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            fc_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            fc_q    <= fc_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Seed latch: seed changes mid-frame are invisible until the next fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xn_q <= '0;
            yn_q <= '0;
        end else if (fill_enter) begin
            xn_q <= seed_xn;
            yn_q <= seed_yn;
        end
    end

    assign field_we    = (state_q == FILL);
    assign field_addr  = field_we ? gen_addr : '0;
    assign field_data  = field_we ? {xn_q, yn_q, gen_mag} : '0;
    assign draw_start  = (state_q == START);
    assign busy        = busy_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_field_sequencer.sv
// Self-checking bench for field_sequencer with a frame-level reference model.
module tb_field_sequencer;
    import field_pkg::*;

    localparam int unsigned FW    = 8;
    localparam int unsigned FH    = 6;
    localparam int unsigned FS    = FW * FH;
    localparam int unsigned AW    = 6;
    localparam int unsigned CW    = 32;
    localparam int unsigned DW    = 3 * CW;
    localparam int unsigned STEP1 = 65536;
    localparam int PH_IDLE  = 0;
    localparam int PH_FRAME = 1;
    localparam int PH_WAIT  = 2;

    logic          MAX10_CLK1_50;
    logic          rst, run, step, frame_tick, draw_done;
    logic [CW-1:0] seed_xn, seed_yn, seed_mag;

    logic          we0, we1, start0, start1, busy0, busy1, to0, to1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic [15:0]   fc0, fc1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_fc   = '0;
    logic        exp_to   = 1'b0;
    int          tick_list[$];

    field_sequencer #(
        .MAG_STEP    (0),
        .TIMEOUT_CYC (100)
    ) dut0 (
        .clk (MAX10_CLK1_50), .rst (rst), .run (run), .step (step),
        .frame_tick (frame_tick), .seed_xn (seed_xn), .seed_yn (seed_yn),
        .seed_mag (seed_mag), .field_we (we0), .field_addr (addr0),
        .field_data (data0), .draw_start (start0), .draw_done (draw_done),
        .busy (busy0), .frame_count (fc0), .timeout (to0)
    );

    field_sequencer #(
        .MAG_STEP    (STEP1),
        .TIMEOUT_CYC (100)
    ) dut1 (
        .clk (MAX10_CLK1_50), .rst (rst), .run (run), .step (step),
        .frame_tick (frame_tick), .seed_xn (seed_xn), .seed_yn (seed_yn),
        .seed_mag (seed_mag), .field_we (we1), .field_addr (addr1),
        .field_data (data1), .draw_start (start1), .draw_done (draw_done),
        .busy (busy1), .frame_count (fc1), .timeout (to1)
    );

    initial begin
        MAX10_CLK1_50 = 1'b0;
        forever #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;
    end

    // Entry written at address a: column ramp computed directly as col*step.
    function automatic logic [DW-1:0] model_entry(input int unsigned a, input logic [CW-1:0] xn,
                                                  input logic [CW-1:0] yn, input logic [CW-1:0] mag,
                                                  input int unsigned stp);
        field_entry_t e;
        e.xn  = xn;
        e.yn  = yn;
        e.mag = mag + CW'((a % FW) * stp);
        return e;
    endfunction

    // Drive a schedule and compare every cycle against the frame-level model.
    task automatic run_sched(input string tag, input int n_iter, input int run_until,
                             input bit step_first, input int tick_period, input int tick_pct,
                             input int lat_min, input int lat_max, input bit noise,
                             input logic [CW-1:0] xn0, input logic [CW-1:0] yn0,
                             input logic [CW-1:0] mag0);
        int            phase   = PH_IDLE;
        int            s       = 0;
        int            done_at = -1;
        bit            pend    = 1'b0;
        logic [CW-1:0] lx = '0, ly = '0, lm = '0;
        for (int i = 0; i < n_iter; i++) begin
            bit            r, st, tk, dn_real, dn, start_now, exp_we, exp_st, exp_busy;
            logic [DW-1:0] e0, e1;
            r  = (i < run_until);
            st = step_first && (i == 0);
            tk = 1'b0;
            if (r) begin
                if (tick_period != 0 && (i % tick_period) == tick_period - 1) tk = 1'b1;
                foreach (tick_list[k]) if (tick_list[k] == i) tk = 1'b1;
                if (tick_pct != 0 && $urandom_range(99) < tick_pct) tk = 1'b1;
            end
            dn_real = (phase == PH_FRAME) && (i == done_at);
            dn      = dn_real;
            if (noise) begin
                if (phase != PH_IDLE && $urandom_range(7) == 0) st = 1'b1;
                if (!dn_real && (phase != PH_FRAME || i <= s + 49) && $urandom_range(7) == 0)
                    dn = 1'b1;
            end
            if (i == 0) begin
                seed_xn = xn0; seed_yn = yn0; seed_mag = mag0;
            end else begin
                seed_xn = $urandom; seed_yn = $urandom; seed_mag = $urandom;
            end
            run = r; step = st; frame_tick = tk; draw_done = dn;

            start_now = 1'b0;
            case (phase)
                PH_IDLE: begin
                    pend = 1'b0;
                    if (r || st) start_now = 1'b1;
                end
                PH_FRAME: begin
                    if (tk) pend = 1'b1;
                    if (dn_real) begin
                        exp_fc = exp_fc + 16'd1;
                        phase  = r ? PH_WAIT : PH_IDLE;
                    end
                end
                default: begin
                    if (!r) phase = PH_IDLE;
                    else if (tk || pend) start_now = 1'b1;
                end
            endcase
            if (start_now) begin
                phase   = PH_FRAME;
                s       = i;
                done_at = i + 48 + int'($urandom_range(lat_max, lat_min));
                pend    = 1'b0;
                lx = seed_xn; ly = seed_yn; lm = seed_mag;
            end

            @(posedge MAX10_CLK1_50);
            #1;
            exp_we   = (phase == PH_FRAME) && (i - s <= 47);
            exp_st   = (phase == PH_FRAME) && (i == s + 48);
            exp_busy = (phase != PH_IDLE);
            n_checks++;
            if ({we0, start0, busy0, fc0, to0} !== {exp_we, exp_st, exp_busy, exp_fc, exp_to}) begin
                n_errors++;
                $display("FAIL %s ctrl0 it=%0d got we=%b st=%b busy=%b fc=%0d to=%b want %b %b %b %0d %b",
                         tag, i, we0, start0, busy0, fc0, to0, exp_we, exp_st, exp_busy, exp_fc, exp_to);
            end
            n_checks++;
            if ({we1, start1, busy1, fc1, to1} !== {exp_we, exp_st, exp_busy, exp_fc, exp_to}) begin
                n_errors++;
                $display("FAIL %s ctrl1 it=%0d got we=%b st=%b busy=%b fc=%0d to=%b want %b %b %b %0d %b",
                         tag, i, we1, start1, busy1, fc1, to1, exp_we, exp_st, exp_busy, exp_fc, exp_to);
            end
            if (exp_we) begin
                e0 = model_entry(i - s, lx, ly, lm, 0);
                e1 = model_entry(i - s, lx, ly, lm, STEP1);
                n_checks++;
                if ({addr0, data0} !== {AW'(i - s), e0}) begin
                    n_errors++;
                    $display("FAIL %s write0 it=%0d got addr=%0d data=%h want addr=%0d data=%h",
                             tag, i, addr0, data0, i - s, e0);
                end
                n_checks++;
                if ({addr1, data1} !== {AW'(i - s), e1}) begin
                    n_errors++;
                    $display("FAIL %s write1 it=%0d got addr=%0d data=%h want addr=%0d data=%h",
                             tag, i, addr1, data1, i - s, e1);
                end
            end
        end
        run = 1'b0; step = 1'b0; frame_tick = 1'b0; draw_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; frame_tick = 1'b0; draw_done = 1'b0;
        seed_xn = $urandom; seed_yn = $urandom; seed_mag = $urandom;
        repeat (3) @(posedge MAX10_CLK1_50);
        #1;
        n_checks++;
        if ({we0, addr0, data0, start0, busy0, fc0, to0, we1, addr1, data1, start1, busy1, fc1, to1}
            !== '0) begin
            n_errors++;
            $display("FAIL reset_state got we=%b addr=%0d start=%b busy=%b fc=%0d to=%b want all 0",
                     we0, addr0, start0, busy0, fc0, to0);
        end
        rst = 1'b0;
        exp_fc = '0;
    endtask

    task automatic test_single_step();
        run_sched("step", 120, 0, 1'b1, 0, 0, 20, 20, 1'b0, 32'd46341, 32'd46341, 32'd50 << 16);
    endtask

    task automatic test_mag_ramp();
        run_sched("ramp", 120, 0, 1'b1, 0, 0, 20, 20, 1'b0, $urandom, $urandom, 32'd0);
        run_sched("ramp_noise", 160, 0, 1'b1, 0, 0, 5, 30, 1'b1, $urandom, $urandom, $urandom);
    endtask

    task automatic test_continuous();
        tick_list.delete();
        run_sched("cont", 800, 650, 1'b0, 200, 0, 20, 20, 1'b0, $urandom, $urandom, $urandom);
    endtask

    task automatic test_back_to_back();
        tick_list.delete();
        tick_list.push_back(10);
        tick_list.push_back(30);
        run_sched("pend2", 260, 200, 1'b0, 0, 0, 20, 20, 1'b0, $urandom, $urandom, $urandom);
        tick_list.delete();
        tick_list.push_back(68);
        run_sched("pend_at_done", 260, 200, 1'b0, 0, 0, 20, 20, 1'b0, $urandom, $urandom, $urandom);
        tick_list.delete();
    endtask

    task automatic test_random();
        run_sched("random", 2700, 2500, 1'b0, 0, 2, 2, 40, 1'b1, $urandom, $urandom, $urandom);
    endtask

    task automatic test_reset_mid_fill();
        bit hit = 1'b0;
        seed_xn = $urandom; seed_yn = $urandom; seed_mag = $urandom;
        step = 1'b1;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge MAX10_CLK1_50);
            #1;
            step = 1'b0;
            if (we0 === 1'b1 && addr0 === 6'd20) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL rst_mid_wait got no write at addr 20 within 100 cycles, want one");
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({we0, addr0, data0, start0, busy0, fc0, to0, we1, addr1, data1, start1, busy1, fc1, to1}
            !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs got we=%b addr=%0d start=%b busy=%b fc=%0d to=%b want all 0",
                     we0, addr0, start0, busy0, fc0, to0);
        end
        @(posedge MAX10_CLK1_50);
        #1;
        rst = 1'b0;
        exp_fc = '0;
        exp_to = 1'b0;
        run_sched("after_rst", 120, 0, 1'b1, 0, 0, 20, 20, 1'b0, $urandom, $urandom, $urandom);
    endtask

`ifdef FIELD_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int s = -1;
        step = 1'b1;
        for (int i = 0; i < 220; i++) begin
            @(posedge MAX10_CLK1_50);
            #1;
            step = 1'b0;
            if (s < 0 && we0 === 1'b1) s = i;
            if (s >= 0 && i == s + 148) begin
                n_checks++;
                if ({busy0, to0, busy1, to1} !== 4'b1010) begin
                    n_errors++;
                    $display("FAIL timeout_early got busy=%b to=%b want busy=1 to=0", busy0, to0);
                end
            end
            if (s >= 0 && i == s + 149) begin
                n_checks++;
                if ({busy0, to0, fc0, busy1, to1, fc1} !== {2'b01, exp_fc, 2'b01, exp_fc}) begin
                    n_errors++;
                    $display("FAIL timeout_fire got busy=%b to=%b fc=%0d want busy=0 to=1 fc=%0d",
                             busy0, to0, fc0, exp_fc);
                end
            end
        end
        n_checks++;
        if (s != 0) begin
            n_errors++;
            $display("FAIL timeout_start got first write at it=%0d want 0", s);
        end
        exp_to = 1'b1;
        run_sched("after_timeout", 120, 0, 1'b1, 0, 0, 20, 20, 1'b0, $urandom, $urandom, $urandom);
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_mag_ramp();
        test_continuous();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
`ifdef FIELD_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/field_sequencer.md
Name: field_sequencer

Overview:
- Frame-level controller that fills the vector-field RAM with FIELD_SIZE entries {xn, yn, mag} and starts the line renderer.
- Waits for the renderer's done, then paces the next frame on a frame tick. Supports continuous and single-step modes.
- Replaces the single-entry, single-shot start logic in the top level.
- Generalised over field dimensions, component width and per-column magnitude ramp.

Parameters:
- FIELD_WIDTH, 8, cells per row
- FIELD_HEIGHT, 6, rows
- COMP_W, 32, width of each component (Q16.16 fixed point at default)
- MAG_STEP, 0, added to mag per column index, modulo 2^COMP_W
- FRAME_CNT_W, 16, width of completed-frame counter
- TIMEOUT_CYC, 1000000, watchdog limit in cycles (used only with the optional feature)
- Derived localparams: FIELD_SIZE = FIELD_WIDTH*FIELD_HEIGHT, FIELD_ADDRW = $clog2(FIELD_SIZE), FIELD_DATAW = 3*COMP_W

Ports:
- clk  in  1  system clock
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- run  in  1  level; continuous operation while high
- step  in  1  one-cycle pulse; run exactly one frame when idle
- frame_tick  in  1  one-cycle pulse per display frame
- seed_xn  in  COMP_W  x direction, signed
- seed_yn  in  COMP_W  y direction, signed
- seed_mag  in  COMP_W  base magnitude, unsigned
- field_we  out  1  field RAM write enable
- field_addr  out  FIELD_ADDRW  write address
- field_data  out  FIELD_DATAW  {xn, yn, mag}, xn in the MSBs
- draw_start  out  1  one-cycle start pulse to the renderer
- draw_done  in  1  renderer completion pulse
- busy  out  1  high in any state except IDLE
- frame_count  out  FRAME_CNT_W  number of completed frames, wraps
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async) values: all outputs 0; state IDLE; counters 0; pending_tick 0.
- IDLE -> FILL when run=1 or step=1. If both are high, run takes precedence.
  - On entering FILL, latch the seeds and clear the col, row and addr counters.
  - Seed changes during a frame have no effect until the next FILL entry.
- FILL: one write per cycle. field_we=1, field_addr=addr.
  - field_data = {xn_l, yn_l, mag_l + col*MAG_STEP}, truncated to COMP_W.
  - Compute the ramp with an accumulator (add MAG_STEP on each col increment, reset to mag_l at col wrap). No multiplier.
  - col wraps FIELD_WIDTH-1 -> 0 and increments row.
  - After writing addr = FIELD_SIZE-1, go to START. FILL lasts exactly FIELD_SIZE cycles.
- START: one cycle. draw_start=1, field_we=0. Next state WAIT_DONE.
- WAIT_DONE: draw_done is sampled only in this state; draw_done in any other state is ignored.
  - On draw_done: frame_count increments (wraps).
  - If run=1, go to WAIT_FRAME; otherwise go to IDLE.
- WAIT_FRAME: go to FILL on frame_tick or pending_tick, and clear pending_tick.
  - If run drops while in WAIT_FRAME, go to IDLE.
- pending_tick: set by frame_tick arriving in FILL, START or WAIT_DONE. Holds one tick; extra ticks are dropped. Cleared in IDLE.
- step pulses while busy=1 are ignored.
- run deasserted mid-frame: the current frame completes, then IDLE.
- busy is registered and equals (state != IDLE).

Optional Feature:
- Macro: FIELD_SEQ_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT_DONE.
  - On reaching TIMEOUT_CYC without draw_done: set timeout (sticky until rst), go to IDLE, frame_count unchanged.
- Undefined: no counter; timeout tied to 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package field_pkg: COMP_W default, typedef field_entry_t packed struct {xn, yn, mag}, and the state enum typedef seq_state_t {IDLE, FILL, START, WAIT_DONE, WAIT_FRAME}.
- One sub-module, field_addr_gen: col/row/addr counters plus the mag ramp accumulator, with a last-cell flag output.

Test Plan:
- Reset then step=1 with seeds (46341, 46341, 50<<16), MAG_STEP=0:
  - 48 consecutive writes, addr 0..47, all data equal to the seeds.
  - draw_start one cycle after addr 47. done -> IDLE, frame_count=1.
- MAG_STEP=65536, seed_mag=0: addr 9 (col 1) mag=65536; addr 15 (col 7) mag=458752; addr 16 (col 0) mag=0.
- run=1 with frame_tick every 200 cycles and draw_done 20 cycles after draw_start: FILL begins only on ticks; frame_count reaches 3 after 3 ticks.
- frame_tick during FILL, done later: immediate WAIT_FRAME -> FILL without a new tick. Two ticks in one frame cause only one extra frame.
- Assert rst mid-FILL at addr 20: all outputs 0 immediately, state IDLE; a following step restarts at addr 0.
- With FIELD_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, no draw_done: timeout=1 after 100 cycles in WAIT_DONE, busy=0, frame_count unchanged.
